// File: rtl/dco_nch_v2.sv
// Multi-channel digitally controlled oscillator with an SFR register interface.
// Each channel runs a phase accumulator and drives a toggle, pulse or MSB output.
module dco_nch_v2 #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    N          = 20,
   parameter int                    CH         = 2
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  sys_clk_en,
   input  logic [3:0]            sys_clk_div,
   input  logic [ADDR_WIDTH-1:0] sys_addr,
   input  logic                  sys_wr_en,
   input  logic [DATA_WIDTH-1:0] sys_sw_value,
   output logic [DATA_WIDTH-1:0] sfr_rd_dout,
   output logic [CH-1:0]         dco_clk_out
);

   typedef enum logic [1:0] {
      MODE_TOGGLE = 2'b00,
      MODE_PULSE  = 2'b01,
      MODE_MSB    = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_e;

   logic [DATA_WIDTH-1:0] ch_rd [CH];
   logic                  unused_bits;

   assign unused_bits = ^sys_sw_value;

   genvar i;
   generate
      for (i = 0; i < CH; i++) begin : g_ch
         localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = BASE_ADDR + ADDR_WIDTH'(8 * i);
         localparam logic [ADDR_WIDTH-1:0] INC_ADDR  = CTRL_ADDR + ADDR_WIDTH'(4);

         logic                  en;
         mode_e                 mode;
         logic [2:0]            clksrc;
         logic                  ovf;
         logic [N-1:0]          inc;
         logic [N-1:0]          acc;
         logic                  out;
         logic [3:0]            div_prev;
         logic                  sel_ctrl;
         logic                  sel_inc;
         logic                  wr_ctrl;
         logic                  wr_inc;
         logic                  tick;
         logic                  step;
         logic                  carry;
         logic [N:0]            sum;
         logic [DATA_WIDTH-1:0] rd_val;

         assign sel_ctrl = (sys_addr == CTRL_ADDR);
         assign sel_inc  = (sys_addr == INC_ADDR);
         assign wr_ctrl  = sys_clk_en & sys_wr_en & sel_ctrl;
         assign wr_inc   = sys_clk_en & sys_wr_en & sel_inc;

         // Divided-clock inputs are treated as data: a tick is a low-to-high step between samples.
         always_comb begin
            tick = 1'b0;
            case (clksrc)
               3'd0:    tick = 1'b1;
               3'd1:    tick = sys_clk_div[0] & ~div_prev[0];
               3'd2:    tick = sys_clk_div[1] & ~div_prev[1];
               3'd3:    tick = sys_clk_div[2] & ~div_prev[2];
               3'd4:    tick = sys_clk_div[3] & ~div_prev[3];
               default: tick = 1'b0;
            endcase
         end

         assign sum   = {1'b0, acc} + {1'b0, inc};
         assign step  = en & tick;
         assign carry = step & sum[N];

         always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
               en       <= 1'b0;
               mode     <= MODE_TOGGLE;
               clksrc   <= 3'd0;
               ovf      <= 1'b0;
               inc      <= '0;
               acc      <= '0;
               out      <= 1'b0;
               div_prev <= 4'd0;
            end else if (sys_clk_en) begin
               div_prev <= sys_clk_div;
               if (!en) begin
                  acc <= '0;
                  out <= 1'b0;
               end else begin
                  if (step) begin
                     acc <= sum[N-1:0];
                  end
                  case (mode)
                     MODE_PULSE: out <= carry;
                     MODE_MSB:   out <= acc[N-1];
                     default:    if (carry) out <= ~out;
                  endcase
               end
               // A carry in the same cycle as a clearing write keeps OVF set.
               if (carry) begin
                  ovf <= 1'b1;
               end else if (wr_ctrl && sys_sw_value[16]) begin
                  ovf <= 1'b0;
               end
               if (wr_ctrl) begin
                  en     <= sys_sw_value[0];
                  mode   <= mode_e'(sys_sw_value[2:1]);
                  clksrc <= sys_sw_value[10:8];
                  if (!sys_sw_value[0]) begin
                     acc <= '0;
                     out <= 1'b0;
                  end
               end
               if (wr_inc) begin
                  inc <= sys_sw_value[N-1:0];
               end
            end
         end

         always_comb begin
            rd_val = '0;
            if (sel_ctrl) begin
               rd_val[0]    = en;
               rd_val[2:1]  = mode;
               rd_val[10:8] = clksrc;
               rd_val[16]   = ovf;
            end else if (sel_inc) begin
               rd_val[N-1:0] = inc;
            end
         end

         assign ch_rd[i]       = rd_val;
         assign dco_clk_out[i] = out;
      end
   endgenerate

   always_comb begin
      sfr_rd_dout = '0;
      for (int k = 0; k < CH; k++) begin
         sfr_rd_dout = sfr_rd_dout | ch_rd[k];
      end
   end

endmodule

// File: tb/tb_dco_nch_v2.sv
// Scoreboard bench for dco_nch_v2: a cycle-level reference model queues expected
// read data and outputs, and an independent monitor compares them against the DUT.
module tb_dco_nch_v2;

   localparam int          DW   = 32;
   localparam int          AW   = 32;
   localparam int          N    = 20;
   localparam int          CH   = 2;
   localparam logic [31:0] BASE = 32'h100;
   localparam int unsigned MOD  = 32'h1 << N;

   logic          sys_clk      = 1'b0;
   logic          sys_rst      = 1'b1;
   logic          sys_clk_en   = 1'b0;
   logic [3:0]    sys_clk_div  = 4'd0;
   logic [AW-1:0] sys_addr     = '0;
   logic          sys_wr_en    = 1'b0;
   logic [DW-1:0] sys_sw_value = '0;
   logic [DW-1:0] sfr_rd_dout;
   logic [CH-1:0] dco_clk_out;

   dco_nch_v2 #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .N(N), .CH(CH)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .sys_clk_en  (sys_clk_en),
      .sys_clk_div (sys_clk_div),
      .sys_addr    (sys_addr),
      .sys_wr_en   (sys_wr_en),
      .sys_sw_value(sys_sw_value),
      .sfr_rd_dout (sfr_rd_dout),
      .dco_clk_out (dco_clk_out)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [31:0] rd;
      logic [31:0] dco;
   } exp_t;

   exp_t        sbQ[$];
   int          checks   = 0;
   int          failures = 0;
   logic [3:0]  curDiv   = 4'd0;

   bit          mEn   [CH];
   int unsigned mMode [CH];
   int unsigned mSrc  [CH];
   int unsigned mInc  [CH];
   int unsigned mAcc  [CH];
   bit          mOvf  [CH];
   bit          mOut  [CH];
   bit [3:0]    mPrev [CH];

   function automatic logic [31:0] ctrlAddr(int c);
      return BASE + 32'(8 * c);
   endfunction

   function automatic logic [31:0] modelRead(logic [31:0] a);
      for (int c = 0; c < CH; c++) begin
         if (a == ctrlAddr(c))
            return (32'(mOvf[c]) << 16) | (mSrc[c] << 8) | (mMode[c] << 1) | 32'(mEn[c]);
         if (a == ctrlAddr(c) + 32'd4)
            return mInc[c];
      end
      return 32'd0;
   endfunction

   function automatic logic [31:0] modelDco();
      logic [31:0] v = '0;
      for (int c = 0; c < CH; c++) v[c] = mOut[c];
      return v;
   endfunction

   task automatic modelStep(input bit rst, input bit ce, input logic [3:0] div,
                            input logic [31:0] a, input bit wr, input logic [31:0] d);
      if (rst) begin
         for (int c = 0; c < CH; c++) begin
            mEn[c] = 0; mMode[c] = 0; mSrc[c] = 0; mInc[c] = 0;
            mAcc[c] = 0; mOvf[c] = 0; mOut[c] = 0; mPrev[c] = 4'd0;
         end
      end else if (ce) begin
         for (int c = 0; c < CH; c++) begin
            int unsigned src   = mSrc[c];
            bit          tick  = (src == 0) ||
                                 (src >= 1 && src <= 4 && div[src-1] && !mPrev[c][src-1]);
            bit          carry = 0;
            int unsigned nAcc  = mAcc[c];
            bit          nOut  = mOut[c];
            if (!mEn[c]) begin
               nAcc = 0;
               nOut = 0;
            end else begin
               if (tick) begin
                  int unsigned total = mAcc[c] + mInc[c];
                  carry = (total >= MOD);
                  nAcc  = total % MOD;
               end
               if (mMode[c] == 2)      nOut = ((mAcc[c] >> (N - 1)) & 1) != 0;
               else if (mMode[c] == 1) nOut = carry;
               else if (carry)         nOut = !mOut[c];
            end
            if (wr && a == ctrlAddr(c)) begin
               if (d[16] && !carry) mOvf[c] = 0;
               mEn[c]   = d[0];
               mMode[c] = 32'(d[2:1]);
               mSrc[c]  = 32'(d[10:8]);
               if (!d[0]) begin
                  nAcc = 0;
                  nOut = 0;
               end
            end
            if (carry) mOvf[c] = 1;
            if (wr && a == ctrlAddr(c) + 32'd4) mInc[c] = d & (MOD - 1);
            mAcc[c]  = nAcc;
            mOut[c]  = nOut;
            mPrev[c] = div;
         end
      end
   endtask

   task automatic applyStimulus(input bit rst, input bit ce, input logic [3:0] div,
                                input logic [31:0] a, input bit wr, input logic [31:0] d);
      exp_t e;
      @(negedge sys_clk);
      sys_rst      = rst;
      sys_clk_en   = ce;
      sys_clk_div  = div;
      sys_addr     = a;
      sys_wr_en    = wr;
      sys_sw_value = d;
      e.rd = modelRead(a);
      modelStep(rst, ce, div, a, wr, d);
      e.dco = modelDco();
      sbQ.push_back(e);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
      applyStimulus(1'b0, 1'b1, curDiv, a, 1'b1, d);
   endtask

   task automatic readCycles(input logic [31:0] a, input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b1, curDiv, a, 1'b0, 32'd0);
   endtask

   // Monitor: reads are sampled mid-cycle, outputs just after the following edge.
   initial begin
      exp_t        e;
      logic [31:0] rdAct;
      forever begin
         @(negedge sys_clk);
         #2;
         if (sbQ.size() > 0) begin
            e     = sbQ.pop_front();
            rdAct = sfr_rd_dout;
            @(posedge sys_clk);
            #1;
            checkOutput("rd_dout", rdAct, e.rd);
            checkOutput("dco_clk_out", 32'(dco_clk_out), e.dco);
         end
      end
   end

   initial begin
      $display("[TB] start");
      for (int k = 0; k < 3; k++)
         applyStimulus(1'b1, 1'b0, 4'd0, ctrlAddr(k % CH) + 32'(4 * (k & 1)), 1'b0, 32'd0);

      writeReg(ctrlAddr(0) + 32'd4, 32'h0008_0000);
      writeReg(ctrlAddr(0), 32'h0000_0001);
      readCycles(ctrlAddr(0), 12);

      writeReg(ctrlAddr(1) + 32'd4, 32'h0004_0000);
      writeReg(ctrlAddr(1), 32'h0000_0003);
      readCycles(ctrlAddr(1), 9);
      for (int k = 0; k < 4; k++) begin
         writeReg(ctrlAddr(1), 32'h0001_0003);
         readCycles(ctrlAddr(1), 1);
      end

      writeReg(ctrlAddr(0), 32'h0000_0205);
      for (int k = 0; k < 48; k++) begin
         if (k % 3 == 0) curDiv[1] = ~curDiv[1];
         applyStimulus(1'b0, 1'b1, curDiv, ctrlAddr(0), 1'b0, 32'd0);
      end
      for (int k = 0; k < 10; k++) begin
         if (k % 3 == 0) curDiv[1] = ~curDiv[1];
         applyStimulus(1'b0, 1'b0, curDiv, ctrlAddr(0) + 32'd4, 1'b1, 32'h0000_1234);
      end
      for (int k = 0; k < 24; k++) begin
         if (k % 3 == 0) curDiv[1] = ~curDiv[1];
         applyStimulus(1'b0, 1'b1, curDiv, ctrlAddr(1), 1'b0, 32'd0);
      end

      readCycles(BASE + 32'd2, 1);
      readCycles(BASE + 32'(8 * CH), 1);
      writeReg(BASE + 32'd2, 32'hFFFF_FFFF);
      writeReg(ctrlAddr(1) + 32'd4, 32'hFFFF_FFFF);
      readCycles(ctrlAddr(1) + 32'd4, 2);
      readCycles(ctrlAddr(1), 4);

      for (int k = 0; k < 800; k++) begin
         logic [31:0] a;
         logic [31:0] d = $urandom;
         int          sel = $urandom_range(7);
         if (sel < 4)       a = ctrlAddr(sel >> 1) + 32'(4 * (sel & 1));
         else if (sel == 4) a = BASE + 32'd2;
         else if (sel == 5) a = BASE + 32'(8 * CH);
         else if (sel == 6) a = BASE + 32'd6;
         else               a = $urandom;
         if (sel < 4 && (sel & 1) == 0) d[0] = ($urandom_range(4) != 0);
         curDiv = 4'($urandom);
         applyStimulus($urandom_range(199) == 0, $urandom_range(9) != 0, curDiv, a,
                       $urandom_range(3) == 0, d);
      end

      writeReg(ctrlAddr(0) + 32'd4, 32'h0008_0000);
      writeReg(ctrlAddr(0), 32'h0000_0001);
      writeReg(ctrlAddr(1) + 32'd4, 32'h0004_0000);
      writeReg(ctrlAddr(1), 32'h0000_0003);
      readCycles(ctrlAddr(0), 5);
      applyStimulus(1'b1, 1'b1, curDiv, ctrlAddr(0), 1'b0, 32'd0);
      for (int c = 0; c < CH; c++) begin
         readCycles(ctrlAddr(c), 1);
         readCycles(ctrlAddr(c) + 32'd4, 1);
      end

      repeat (3) @(negedge sys_clk);
      checkOutput("scoreboard_drain", 32'(sbQ.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dco_nch_v2.md
DCO_NCH_V2 -- requirements
Module: dco_nch_v2

Interface
REQ-001 Parameter DATA_WIDTH, default 32: SFR data bus width.
REQ-002 Parameter ADDR_WIDTH, default 32: SFR address bus width.
REQ-003 Parameter BASE_ADDR, default 0: address of channel 0 CTRL register.
REQ-004 Parameter N, default 20, legal range 4..DATA_WIDTH: phase accumulator and INC width.
REQ-005 Parameter CH, default 2, legal range 1..8: number of independent DCO channels.
REQ-006 sys_clk  input  1  sole clock; all state on rising edge.
REQ-007 sys_rst  input  1  reset, synchronous, active-high.
REQ-008 sys_clk_en  input  1  global enable; when low, no state changes except reset.
REQ-009 sys_clk_div  input  4  divided-clock levels, sampled as data (never used as clocks).
REQ-010 sys_addr  input  ADDR_WIDTH  SFR address.
REQ-011 sys_wr_en  input  1  SFR write strobe.
REQ-012 sys_sw_value  input  DATA_WIDTH  SFR write data.
REQ-013 sfr_rd_dout  output  DATA_WIDTH  combinational read data for sys_addr; 0 when unmapped.
REQ-014 dco_clk_out  output  CH  per-channel DCO output, registered.

Function
REQ-015 Per channel i: CTRL at BASE_ADDR+8*i, INC at BASE_ADDR+8*i+4; any other address (including unaligned) reads 0 and ignores writes.
REQ-016 CTRL bits: [0] EN rw; [2:1] MODE rw (00 toggle, 01 pulse, 10 MSB, 11 reserved = behaves as 00); [10:8] CLKSRC rw; [16] OVF sticky, write-1-to-clear; all other bits read 0.
REQ-017 INC: bits [N-1:0] rw, upper bits read 0.
REQ-018 Write occurs when sys_clk_en & sys_wr_en & address match; takes effect the following cycle.
REQ-019 Tick source per CLKSRC: 000 = every sys_clk_en cycle; 001..100 = rising edge of sys_clk_div[CLKSRC-1], detected by a one-register delay (previous-sample low, current high); 101..111 = no ticks.
REQ-020 Edge-detect registers update on every sys_clk_en cycle regardless of EN.
REQ-021 On a tick with EN=1: ACC <= (ACC + INC) mod 2^N; carry = bit N of the N+1-bit sum.
REQ-022 MODE 00: output toggles on cycle after a carry tick; MODE 01: output high for exactly one cycle after each carry tick, else low; MODE 10: output = ACC[N-1] (registered copy).
REQ-023 Carry sets OVF; simultaneous carry and W1C write to OVF: set wins.
REQ-024 EN=0: ACC held at 0, output 0; writing EN 1->0 clears ACC and output on the next cycle; OVF retained.
REQ-025 INC write while running does not reset ACC; new INC used from the next tick.
REQ-026 INC=0: ACC constant, no carry, output static.
REQ-027 MODE change while running: ACC unaffected; output re-evaluated per new mode from the next cycle.
REQ-028 Channels fully independent; no shared state except address decode.

Reset
REQ-029 sys_rst high on a rising edge: all CTRL, INC, ACC, OVF, edge-detect registers and dco_clk_out cleared to 0 regardless of sys_clk_en.
REQ-030 Reset mid-operation aborts immediately; first tick possible is the cycle after reset deasserts and EN is written.
REQ-031 sfr_rd_dout is 0 for all addresses while registers are in reset state.

Verification
REQ-032 N=20, ch0: INC=0x80000, CTRL=0x001 (tick every cycle, toggle) -> carry every 2nd cycle, dco_clk_out[0] period 4 cycles, OVF reads 1.
REQ-033 ch1: INC=0x40000, CTRL=0x003 (pulse) -> 1-cycle pulse every 4 cycles; write CTRL=0x10003 on a carry cycle -> OVF still 1.
REQ-034 ch0: CLKSRC=010, sys_clk_div[1] toggling every 3 cycles, INC=0x80000, MODE 10 -> ACC advances once per 6 cycles, output = ACC[19].
REQ-035 sys_clk_en low for 10 cycles mid-run -> ACC, outputs, edge registers frozen; resume with identical sequence.
REQ-036 Read of BASE_ADDR+2, BASE_ADDR+8*CH, and INC upper bits -> 0; write 0xFFFF_FFFF to INC reads back 0x000F_FFFF.
REQ-037 Assert sys_rst mid-run -> next cycle all outputs 0, all registers read 0.
